// File: rtl/sblk_pkg.sv
// Shared types and defaults for the superblock psum drain path.
package sblk_pkg;

  // Default width of one psum lane; each column carries a pair of lanes.
  localparam int WID_PSUM_DEF = 32;

  // One column's lane pair at the default lane width.
  typedef logic [2*WID_PSUM_DEF-1:0] psum_pair_t;

  // Serializer states: waiting for a buffered row, or streaming one out.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } drain_state_e;

endpackage

// File: rtl/sblk_psum_fifo.sv
// Synchronous FIFO of aligned row words with a registered read on pop.
// The read register doubles as the serializer's row register: it only
// changes when a row is popped, so it holds steady while the row is emitted.
module sblk_psum_fifo
  import sblk_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int WID_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WID_CNT = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WID_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [WID_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [WID_CNT-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               do_pop;

  function automatic logic [WID_PTR-1:0] ptr_inc(input logic [WID_PTR-1:0] p);
    return (p == WID_PTR'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == WID_CNT'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rd_data = rd_data_q;

  // Pointer, occupancy and read-register next state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers and read data, cleared by reset.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_l) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/sblk_psum_drain.sv
// Deskews the staggered per-column psum read bus of a superblock row,
// buffers whole rows and serializes them one column per beat onto a
// valid/ready stream. The row cannot stall, so admission is controlled by
// reserving a FIFO slot per accepted row (drain_rdy). Assumes N_COLUMN >= 2.
module sblk_psum_drain
  import sblk_pkg::*;
#(
  parameter int N_COLUMN   = 4,
  parameter int WID_PSUM   = WID_PSUM_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int WID_COL    = $clog2(N_COLUMN),
  parameter int WID_CNT    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk_l,
  input  logic                             rst_n,
  input  logic [2*WID_PSUM*N_COLUMN-1:0]   psum_rd_data,
  input  logic                             psum_rd_vld,
  output logic                             drain_rdy,
  output logic [2*WID_PSUM-1:0]            out_data,
  output logic [WID_COL-1:0]               out_col,
  output logic                             out_last,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic                             status_drain,
  output logic                             err_ovf
);

  localparam int WID_PAIR = 2 * WID_PSUM;
  localparam int WID_ROW  = WID_PAIR * N_COLUMN;
  localparam int N_STG    = N_COLUMN - 1;
  localparam logic [WID_COL-1:0] LAST_COL = WID_COL'(N_COLUMN - 1);

  logic [WID_CNT-1:0] resv_cnt_q, resv_cnt_d;
  logic               err_ovf_q, err_ovf_d;
  logic [N_STG-1:0]   vld_sr_q, vld_sr_d;
  logic [WID_ROW-1:0] row_aligned;
  logic [WID_ROW-1:0] row_q;
  logic               accept, last_hs;
  logic               fifo_pop, fifo_empty, fifo_full;
  drain_state_e       state_q, state_d;
  logic [WID_COL-1:0] col_q, col_d;
  logic               out_vld_q, out_vld_d;

  // ---------------------------------------------------------------------------
  // Reservation: one slot per accepted row, released on the row's last beat.
  // A vld arriving without a free slot is dropped and flagged.
  // ---------------------------------------------------------------------------
  assign drain_rdy    = (resv_cnt_q < WID_CNT'(FIFO_DEPTH));
  assign status_drain = (resv_cnt_q != '0);
  assign err_ovf      = err_ovf_q;
  assign accept       = psum_rd_vld && drain_rdy;
  assign last_hs      = out_vld_q && out_rdy && (col_q == LAST_COL);

  // Reservation counter and sticky overflow flag next state.
  always_comb begin
    case ({accept, last_hs})
      2'b10:   resv_cnt_d = resv_cnt_q + 1'b1;
      2'b01:   resv_cnt_d = resv_cnt_q - 1'b1;
      default: resv_cnt_d = resv_cnt_q;
    endcase
    err_ovf_d = err_ovf_q | (psum_rd_vld && !drain_rdy);
  end

  // Reservation registers.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      resv_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      resv_cnt_q <= resv_cnt_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Deskew: only accepted vlds enter the delay line, which masks dropped rows.
  // Column c waits N_COLUMN-1-c cycles so every column lines up with the last.
  // ---------------------------------------------------------------------------

  // Valid delay line next state.
  always_comb begin
    vld_sr_d[0] = accept;
    for (int k = 1; k < N_STG; k++) begin
      vld_sr_d[k] = vld_sr_q[k-1];
    end
  end

  // Valid delay line registers.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
    end
  end

  for (genvar gi = 0; gi < N_COLUMN; gi++) begin : g_col
    localparam int STG = N_COLUMN - 1 - gi;
    if (STG == 0) begin : g_pass
      assign row_aligned[gi*WID_PAIR +: WID_PAIR] = psum_rd_data[gi*WID_PAIR +: WID_PAIR];
    end else begin : g_skew
      logic [WID_PAIR-1:0] sr_q [STG];
      logic [WID_PAIR-1:0] sr_d [STG];

      // Column shift register next state; free-running, never stalls.
      always_comb begin
        sr_d[0] = psum_rd_data[gi*WID_PAIR +: WID_PAIR];
        for (int k = 1; k < STG; k++) begin
          sr_d[k] = sr_q[k-1];
        end
      end

      // Column shift register stages.
      always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < STG; k++) begin
            sr_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < STG; k++) begin
            sr_q[k] <= sr_d[k];
          end
        end
      end

      assign row_aligned[gi*WID_PAIR +: WID_PAIR] = sr_q[STG-1];
    end
  end

  // The full guard is redundant with the reservation; it keeps the FIFO
  // state consistent even if the controller misbehaves.
  sblk_psum_fifo #(
    .WIDTH (WID_ROW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_l   (clk_l),
    .rst_n   (rst_n),
    .push    (vld_sr_q[N_STG-1] && !fifo_full),
    .wr_data (row_aligned),
    .pop     (fifo_pop),
    .rd_data (row_q),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Serializer: the FIFO read register holds the current row; col selects
  // the lane pair. Rows chain back to back without a bubble.
  // ---------------------------------------------------------------------------
  assign out_vld  = out_vld_q;
  assign out_col  = col_q;
  assign out_last = out_vld_q && (col_q == LAST_COL);
  assign out_data = row_q[col_q*WID_PAIR +: WID_PAIR];

  // Serializer next state, column index, stream valid and FIFO pop.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    out_vld_d = out_vld_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          col_d     = '0;
          out_vld_d = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_vld_q && out_rdy) begin
          if (col_q != LAST_COL) begin
            col_d = col_q + 1'b1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            col_d    = '0;
          end else begin
            col_d     = '0;
            out_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        col_d     = '0;
        out_vld_d = 1'b0;
      end
    endcase
  end

  // Serializer registers.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      out_vld_q <= out_vld_d;
    end
  end

endmodule
